// File: rtl/input_bus.sv
// Front-panel input conditioner: 2-flop sync + debounce per channel, bit-reversed buses,
// press pulses and priority-encoded active note. Press pulses are built only when INPUT_BUS_EDGE_EN is defined.
module input_bus #(
    parameter int N_SW     = 7,
    parameter int N_BTN    = 4,
    parameter int DEBOUNCE = 8,
    localparam int CNT_W   = $clog2(DEBOUNCE) + 1,
    localparam int CODE_W  = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SW-1:0]   sw,
    input  logic [N_BTN-1:0]  btn,
    output logic [N_SW-1:0]   sw_bus,
    output logic [N_BTN-1:0]  note_bus,
    output logic [N_BTN-1:0]  note_press,
    output logic [CODE_W-1:0] note_code,
    output logic              note_active
);

    localparam int N_CH = N_SW + N_BTN;

    // Channels 0..N_SW-1 are switches, N_SW..N_CH-1 are buttons.
    logic [N_CH-1:0]  raw;
    logic [N_CH-1:0]  s1;
    logic [N_CH-1:0]  s2;
    logic [N_CH-1:0]  stb;
    logic [N_CH-1:0]  stb_nxt;
    logic [CNT_W-1:0] cnt     [N_CH];
    logic [CNT_W-1:0] cnt_nxt [N_CH];

    logic [N_BTN-1:0]  note_nxt;
    logic [CODE_W-1:0] code_nxt;

    assign raw = {btn, sw};

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            stb_nxt[i] = stb[i];
            cnt_nxt[i] = '0;
            if (s2[i] != stb[i]) begin
                if (cnt[i] == CNT_W'(DEBOUNCE - 1)) begin
                    stb_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_SW; i++) begin
            sw_bus[i] = stb[N_SW - 1 - i];
        end
        for (int unsigned i = 0; i < N_BTN; i++) begin
            note_bus[i] = stb[N_CH - 1 - i];
            note_nxt[i] = stb_nxt[N_CH - 1 - i];
        end
    end

    // Ascending scan so the highest set bit wins.
    always_comb begin
        code_nxt = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (note_nxt[i]) begin
                code_nxt = CODE_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1          <= '0;
            s2          <= '0;
            stb         <= '0;
            cnt         <= '{default: '0};
            note_code   <= '0;
            note_active <= 1'b0;
        end else begin
            s1          <= raw;
            s2          <= s1;
            stb         <= stb_nxt;
            cnt         <= cnt_nxt;
            note_code   <= code_nxt;
            note_active <= |note_nxt;
        end
    end

`ifdef INPUT_BUS_EDGE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_press <= '0;
        end else begin
            note_press <= note_nxt & ~note_bus;
        end
    end
`else
    assign note_press = '0;
`endif

endmodule

// File: tb/tb_input_bus.sv
// Scoreboard bench for input_bus (N_SW=7, N_BTN=4, DEBOUNCE=8); press expectations follow INPUT_BUS_EDGE_EN.
module tb_input_bus;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] sw = '0;
    logic [3:0] btn = '0;
    logic [6:0] sw_bus;
    logic [3:0] note_bus;
    logic [3:0] note_press;
    logic [1:0] note_code;
    logic       note_active;

`ifdef INPUT_BUS_EDGE_EN
    localparam bit PE = 1'b1;
`else
    localparam bit PE = 1'b0;
`endif

    input_bus #(.N_SW(7), .N_BTN(4), .DEBOUNCE(8)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn),
        .sw_bus(sw_bus), .note_bus(note_bus), .note_press(note_press),
        .note_code(note_code), .note_active(note_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [17:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [17:0] obs;

    function automatic logic [17:0] mk(input logic [6:0] s, input logic [3:0] nb,
                                       input logic [3:0] np, input logic [1:0] c, input logic a);
        return {s, nb, np, c, a};
    endfunction

    function automatic logic [3:0] pm(input logic [3:0] p);
        return PE ? p : 4'b0000;
    endfunction

    task automatic push(input int rel, input logic [17:0] v, input string n);
        exp_t x;
        x.cyc = cyc + rel;
        x.val = v;
        x.name = n;
        sb.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        obs = {sw_bus, note_bus, note_press, note_code, note_active};
    endtask

    task automatic test_reset();
        sw = 7'h7f;
        btn = 4'hf;
        #2 rst_n = 1'b1;
        push(9, '0, "all_pre_accept");
        push(10, mk(7'h7f, 4'hf, pm(4'hf), 2'd3, 1'b1), "all_accept");
        repeat (10) begin
            step();
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc %0d got %h exp %h", e.name, cyc, obs, e.val);
                end
            end
        end
        #3 rst_n = 1'b0;
        #1;
        obs = {sw_bus, note_bus, note_press, note_code, note_active};
        checks++;
        if (obs !== 18'h0) begin
            errors++;
            $display("FAIL async_reset got %h exp %h", obs, 18'h0);
        end
        sw = '0;
        btn = '0;
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) push(k, '0, "idle_after_reset");
        repeat (12) begin
            step();
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc %0d got %h exp %h", e.name, cyc, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_switch();
        sw = 7'b1000000;
        push(9, '0, "sw_edge9");
        push(10, mk(7'b0000001, 4'h0, 4'h0, 2'd0, 1'b0), "sw_edge10");
        push(11, mk(7'b0000001, 4'h0, 4'h0, 2'd0, 1'b0), "sw_hold");
        repeat (11) begin
            step();
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc %0d got %h exp %h", e.name, cyc, obs, e.val);
                end
            end
        end
        sw = '0;
        push(9, mk(7'b0000001, 4'h0, 4'h0, 2'd0, 1'b0), "sw_rel_edge9");
        push(10, '0, "sw_rel_edge10");
        repeat (10) begin
            step();
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc %0d got %h exp %h", e.name, cyc, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_glitch();
        btn = 4'b0001;
        for (int k = 1; k <= 20; k++) push(k, '0, "glitch");
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 5) btn = 4'b0000;
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc %0d got %h exp %h", e.name, cyc, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_single_press();
        btn = 4'b0001;
        push(9, '0, "press_edge9");
        push(10, mk(7'h0, 4'b1000, pm(4'b1000), 2'd3, 1'b1), "press_edge10");
        push(11, mk(7'h0, 4'b1000, 4'b0000, 2'd3, 1'b1), "press_pulse_end");
        repeat (11) begin
            step();
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc %0d got %h exp %h", e.name, cyc, obs, e.val);
                end
            end
        end
        btn = 4'b0000;
        push(9, mk(7'h0, 4'b1000, 4'b0000, 2'd3, 1'b1), "release_edge9");
        push(10, '0, "release_edge10");
        push(11, '0, "release_no_pulse");
        repeat (11) begin
            step();
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc %0d got %h exp %h", e.name, cyc, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        btn = 4'b1010;
        push(9, '0, "simul_edge9");
        push(10, mk(7'h0, 4'b0101, pm(4'b0101), 2'd2, 1'b1), "simul_edge10");
        push(11, mk(7'h0, 4'b0101, 4'b0000, 2'd2, 1'b1), "simul_pulse_end");
        repeat (11) begin
            step();
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc %0d got %h exp %h", e.name, cyc, obs, e.val);
                end
            end
        end
        btn = 4'b0000;
        push(10, '0, "simul_release");
        repeat (10) begin
            step();
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc %0d got %h exp %h", e.name, cyc, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        btn = 4'b0001;
        // Six edges: s2 rises at edge 2, counter reads 4 after edge 6.
        for (int k = 1; k <= 6; k++) push(k, '0, "mid_pre_reset");
        repeat (6) begin
            step();
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc %0d got %h exp %h", e.name, cyc, obs, e.val);
                end
            end
        end
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) push(k, '0, "mid_restart");
        push(10, mk(7'h0, 4'b1000, pm(4'b1000), 2'd3, 1'b1), "mid_accept");
        push(11, mk(7'h0, 4'b1000, 4'b0000, 2'd3, 1'b1), "mid_pulse_end");
        repeat (11) begin
            step();
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc %0d got %h exp %h", e.name, cyc, obs, e.val);
                end
            end
        end
        btn = 4'b0000;
        repeat (12) step();
    endtask

    initial begin
        test_reset();
        test_switch();
        test_glitch();
        test_single_press();
        test_simultaneous();
        test_reset_mid_debounce();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
